// File: rtl/instr_encoder.sv
// RV32I instruction encoder / program loader: turns field tuples into instruction
// words and streams them into instruction memory through a backpressured write port.
module instr_encoder #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                DEPTH_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_cls,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [15:0]       count,
  output logic              err_illegal,
  output logic              err_full,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // the valid side holds its payload stable until then and never waits on ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2
  } state_t;

  localparam logic [16:0] DEPTH17 = 17'(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic              out_valid_q;
  logic [31:0]       wr_data_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [15:0]       count_q;
  logic              err_illegal_q;
  logic              err_full_q;

  logic [16:0] fill;
  logic        wr_fire;
  logic        acc;
  logic [31:0] enc;
  logic        legal;
  logic        imm12_ok, immb_ok, immj_ok;

  // Words written plus the word waiting at the memory port.
  assign fill     = {1'b0, count_q} + {16'd0, out_valid_q};
  assign wr_fire  = out_valid_q && wr_ready;
  assign in_ready = (state_q == S_RUN) && !start && (!out_valid_q || wr_ready) && (fill < DEPTH17);
  assign acc      = in_valid && in_ready;

  assign imm12_ok = (&in_imm[31:11]) || (~|in_imm[31:11]);
  assign immb_ok  = ((&in_imm[31:12]) || (~|in_imm[31:12])) && !in_imm[0];
  assign immj_ok  = ((&in_imm[31:20]) || (~|in_imm[31:20])) && !in_imm[0];

  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (in_cls)
      3'd0: begin
        enc   = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
        legal = imm12_ok && !(in_funct3 == 3'b011 || in_funct3 == 3'b110 || in_funct3 == 3'b111);
      end
      3'd1: begin
        enc   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
        legal = imm12_ok && (in_funct3 < 3'b011);
      end
      3'd2: begin
        enc   = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
        legal = !in_funct7b5 || in_funct3 == 3'b000 || in_funct3 == 3'b101;
      end
      3'd3: begin
        enc   = {in_imm[31:12], in_rd, 7'b0110111};
        legal = (in_imm[11:0] == 12'd0);
      end
      3'd4: begin
        enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], 7'b1100011};
        legal = immb_ok && !(in_funct3 == 3'b010 || in_funct3 == 3'b011);
      end
      3'd5: begin
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
          enc   = {1'b0, in_funct7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          legal = (in_imm[31:5] == 27'd0);
        end else begin
          enc   = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          legal = imm12_ok;
        end
      end
      3'd6: begin
        enc   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        legal = immj_ok;
      end
      default: begin
        enc   = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
        legal = imm12_ok;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_RUN;
    end else if (state_q == S_RUN && wr_fire && ({1'b0, count_q} + 17'd1 >= DEPTH17)) begin
      state_d = S_FULL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      wr_data_q     <= '0;
      ptr_q         <= '0;
      count_q       <= '0;
      err_illegal_q <= 1'b0;
      err_full_q    <= 1'b0;
    end else if (start) begin
      out_valid_q   <= 1'b0;
      ptr_q         <= BASE_ADDR;
      count_q       <= '0;
      err_illegal_q <= 1'b0;
      err_full_q    <= 1'b0;
    end else begin
      out_valid_q <= (out_valid_q && !wr_ready) || (acc && legal);
      if (acc && legal) begin
        wr_data_q <= enc;
      end
      if (acc && !legal) begin
        err_illegal_q <= 1'b1;
      end
      if (wr_fire) begin
        ptr_q <= ptr_q + ADDR_W'(4);
        if ({1'b0, count_q} < DEPTH17) begin
          count_q <= count_q + 16'd1;
        end
      end
      if (in_valid && state_q != S_IDLE && fill >= DEPTH17) begin
        err_full_q <= 1'b1;
      end
    end
  end

  assign wr_en       = out_valid_q;
  assign wr_addr     = ptr_q;
  assign wr_data     = wr_data_q;
  assign count       = count_q;
  assign err_illegal = err_illegal_q;
  assign err_full    = err_full_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded RV32I words, stalls, illegal
// tuples, full/restart and reset-during-write, with a write scoreboard.
module tb_instr_encoder;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_cls = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_funct7b5 = 1'b0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        wr_en;
  logic        wr_ready = 1'b1;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [15:0] count;
  logic        err_illegal, err_full, busy;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_ptr = BASE;
  int fire_cyc[$];

  instr_encoder #(
    .ADDR_W(32),
    .BASE_ADDR(BASE),
    .DEPTH_WORDS(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cls(in_cls), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .count(count), .err_illegal(err_illegal), .err_full(err_full),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every completed write must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && wr_en && wr_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(wr_en), 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e[63:32]);
        check("wr_data", wr_data, e[31:0]);
        fire_cyc.push_back(cyc);
      end
    end
  end

  // Driver tasks
  task automatic set_fields(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm);
    in_cls = cls; in_funct3 = f3; in_funct7b5 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic send(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic legal, input logic [31:0] word);
    int n;
    n = 0;
    set_fields(cls, f3, f7, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else if (legal) begin
      exp_q.push_back({exp_ptr, word});
      exp_ptr += 32'd4;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !wr_en) && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("drain", 32'(exp_q.size()) | 32'(wr_en), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    exp_q.delete();
    exp_ptr = BASE;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state
    wr_ready = 1'b1;
    set_fields(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_err_illegal", 32'(err_illegal), 32'd0);
    check("rst_err_full", 32'(err_full), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_no_write", 32'(wr_en), 32'd0);

    // Start cycle blocks acceptance; then addi x1,x0,5
    @(posedge clk); #1;
    start = 1'b1;
    exp_ptr = BASE;
    @(negedge clk);
    check("start_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("run_state", 32'(dbg_state), 32'd1);
    check("run_busy", 32'(busy), 32'd1);
    send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093);
    idle();
    drain();
    check("count_after_addi", 32'(count), 32'd1);

    // Back-to-back sw, beq, jal
    fire_cyc.delete();
    send(3'd1, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020_A423);
    send(3'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE00_0EE3);
    send(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h0010_00EF);
    idle();
    drain();
    check("count_after_burst", 32'(count), 32'd4);
    check("full_state", 32'(dbg_state), 32'd2);
    if (fire_cyc.size() == 3) check("burst_throughput", 32'(fire_cyc[2] - fire_cyc[0]), 32'd2);
    else check("burst_writes", 32'(fire_cyc.size()), 32'd3);

    // Backpressure: memory stalls for 3 cycles
    do_start();
    wr_ready = 1'b0;
    fork
      begin
        send(3'd0, 3'd2, 1'b0, 5'd5, 5'd2, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF1_2283);
        send(3'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h4020_81B3);
        send(3'd3, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_5237);
        idle();
      end
      begin
        n = 0;
        @(negedge clk);
        while (!wr_en && n < 20) begin
          n++;
          @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
          check("stall_wr_en", 32'(wr_en), 32'd1);
          check("stall_wr_addr", wr_addr, BASE);
          check("stall_wr_data", wr_data, 32'hFFF1_2283);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          if (i < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        wr_ready = 1'b1;
      end
    join
    drain();
    check("count_after_stall", 32'(count), 32'd3);

    // Illegal tuples are consumed without writes
    do_start();
    check("start_clears_count", 32'(count), 32'd0);
    send(3'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd3, 1'b0, 32'd0);
    send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0, 32'd0);
    send(3'd1, 3'd3, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0, 1'b0, 32'd0);
    send(3'd3, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'h0000_0123, 1'b0, 32'd0);
    send(3'd2, 3'd1, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'd0);
    send(3'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4096, 1'b0, 32'd0);
    send(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2049, 1'b0, 32'd0);
    send(3'd0, 3'd3, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0);
    send(3'd5, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32, 1'b0, 32'd0);
    idle();
    repeat (3) @(negedge clk);
    check("illegal_flag", 32'(err_illegal), 32'd1);
    check("illegal_count", 32'(count), 32'd0);
    check("illegal_no_write", 32'(wr_en), 32'd0);
    @(posedge clk); #1;
    send(3'd5, 3'd5, 1'b1, 5'd6, 5'd7, 5'd0, 32'd3, 1'b1, 32'h4033_D313);
    send(3'd7, 3'd3, 1'b0, 5'd1, 5'd5, 5'd0, 32'd4, 1'b1, 32'h0042_80E7);
    send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2047, 1'b1, 32'h7FF0_0093);
    send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 1'b1, 32'h8000_0093);
    idle();
    drain();
    check("illegal_sticky", 32'(err_illegal), 32'd1);
    check("count_after_legal", 32'(count), 32'd4);

    // Full: fifth tuple refused, then restart
    do_start();
    check("start_clears_illegal", 32'(err_illegal), 32'd0);
    send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093);
    send(3'd1, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020_A423);
    send(3'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE00_0EE3);
    send(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h0010_00EF);
    set_fields(3'd5, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_err_full", 32'(err_full), 32'd1);
    check("full_state2", 32'(dbg_state), 32'd2);
    check("full_count", 32'(count), 32'd4);
    @(posedge clk); #1;
    idle();
    drain();
    do_start();
    check("restart_count", 32'(count), 32'd0);
    check("restart_err_full", 32'(err_full), 32'd0);
    check("restart_state", 32'(dbg_state), 32'd1);
    send(3'd3, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_5237);
    idle();
    drain();
    check("restart_count_1", 32'(count), 32'd1);

    // Reset while a write is stalled
    wr_ready = 1'b0;
    send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093);
    idle();
    n = 0;
    @(negedge clk);
    while (!wr_en && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("pre_reset_wr_en", 32'(wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_wr_en", 32'(wr_en), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_count", 32'(count), 32'd0);
    check("mid_reset_addr", wr_addr, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr_ready = 1'b1;
    set_fields(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_in_ready", 32'(in_ready), 32'd0);
    check("post_reset_wr_en", 32'(wr_en), 32'd0);
    idle();
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
